// File: rtl/nco_ctrl_pkg.sv
// Shared constants and FSM state type for the NCO control path (tuning-word
// loader and its testbenches).
package nco_ctrl_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam logic [7:0]  CMD_SET_FTW = 8'h01;
  localparam logic [63:0] DEFAULT_FTW = 64'h3000000000000000;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    DATA,
    CHK,
    COMMIT
  } loader_state_e;

endpackage

// File: rtl/ftw_ramp.sv
// Slew limiter for the tuning word: moves the output toward a target by at most
// STEP per cycle and pulses done on the cycle the target is reached.
module ftw_ramp #(
  parameter int           W    = 64,
  parameter logic [W-1:0] INIT = W'(nco_ctrl_pkg::DEFAULT_FTW),
  parameter logic [W-1:0] STEP = W'(64'h0000010000000000)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         done,
  output logic         active
);

  logic [W-1:0] target_q;
  logic [W-1:0] goal;
  logic [W-1:0] next_value;

  // A load retargets from wherever the output currently sits; distances are
  // compared before stepping so the unsigned add/subtract can never wrap.
  always_comb begin
    goal       = load ? load_value : target_q;
    next_value = value;
    if (value < goal) begin
      next_value = (goal - value <= STEP) ? goal : value + STEP;
    end else if (value > goal) begin
      next_value = (value - goal <= STEP) ? goal : value - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= INIT;
      value    <= INIT;
      done     <= 1'b0;
    end else begin
      target_q <= goal;
      value    <= next_value;
      done     <= (next_value == goal) && (load || (value != goal));
    end
  end

  assign active = (value != target_q);

endmodule

// File: rtl/ftw_loader.sv
// Assembles a framed 64-bit tuning word from the host byte stream, validates it
// and drives the NCO phase increment. Define FTW_RAMP_EN to slew instead of jump.
module ftw_loader #(
  parameter int               FTW_W          = 64,
  parameter logic [FTW_W-1:0] DEFAULT_FTW    = FTW_W'(nco_ctrl_pkg::DEFAULT_FTW),
  parameter int               TIMEOUT_CYCLES = 80000
`ifdef FTW_RAMP_EN
  ,
  parameter logic [FTW_W-1:0] RAMP_STEP      = FTW_W'(64'h0000010000000000)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [FTW_W-1:0] phase_inc,
  output logic             ftw_update,
  output logic [7:0]       frame_err_cnt,
  output logic             busy
);

  import nco_ctrl_pkg::*;

  localparam int N_BYTES = FTW_W / 8;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int GAP_W   = $clog2(TIMEOUT_CYCLES);

  loader_state_e    state_q, state_d;
  logic             ready_en_q;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       err_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       chk_q;
  logic [FTW_W-1:0] shadow_q;
  logic             accept;
  logic             timeout;
  logic             err_inc;
  logic             commit;
  logic             ramp_active;

  assign in_ready      = ready_en_q && (state_q != COMMIT);
  assign accept        = in_valid && in_ready;
  assign frame_err_cnt = err_q;
  assign busy          = (state_q != HUNT) || ramp_active;

  // An accepted byte on the expiry edge beats the timeout.
  assign timeout = (state_q inside {CMD, DATA, CHK}) && !accept &&
                   (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (accept && in_data == SYNC_BYTE) state_d = CMD;
      end
      CMD: begin
        if (accept) begin
          if (in_data == CMD_SET_FTW) begin
            state_d = DATA;
          end else begin
            state_d = HUNT;
            err_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept && idx_q == IDX_W'(N_BYTES - 1)) state_d = CHK;
      end
      CHK: begin
        if (accept) begin
          if (in_data == chk_q) begin
            state_d = COMMIT;
          end else begin
            state_d = HUNT;
            err_inc = 1'b1;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    if (timeout) begin
      state_d = HUNT;
      err_inc = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset is synchronous, checked on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      ready_en_q <= 1'b0;
      gap_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (state_q == HUNT || accept || timeout) begin
        gap_q <= '0;
      end else begin
        gap_q <= gap_q + GAP_W'(1);
      end
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  // NOTE: the frame datapath has no reset; each field is written inside the
  // frame before it is read, and a reset returns the FSM to HUNT anyway.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == CMD) begin
        chk_q <= in_data;
        idx_q <= '0;
      end
      if (state_q == DATA) begin
        shadow_q <= {shadow_q[FTW_W-9:0], in_data};
        chk_q    <= chk_q ^ in_data;
        idx_q    <= idx_q + IDX_W'(1);
      end
    end
  end

`ifdef FTW_RAMP_EN
  ftw_ramp #(
    .W    (FTW_W),
    .INIT (DEFAULT_FTW),
    .STEP (RAMP_STEP)
  ) u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (commit),
    .load_value (shadow_q),
    .value      (phase_inc),
    .done       (ftw_update),
    .active     (ramp_active)
  );
`else
  assign ramp_active = 1'b0;

  // The whole word moves in one edge, so the NCO never sees a partial value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_inc  <= DEFAULT_FTW;
      ftw_update <= 1'b0;
    end else begin
      ftw_update <= commit;
      if (commit) phase_inc <= shadow_q;
    end
  end
`endif

endmodule
